// File: rtl/mips_boot_sequencer_if.sv
// Program-image stream and CPU load-port signals shared by the boot sequencer and its host.
interface mips_boot_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] address;
  logic [31:0]       inst_data;
  logic              write_instruction;
  logic              write_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, address, inst_data, write_instruction, write_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, address, inst_data, write_instruction, write_data
  );
endinterface

// File: rtl/mips_boot_sequencer.sv
// Boot sequencer for the mini-MIPS: streams a header plus instruction/data image into the
// CPU memories while the CPU is held in reset, then runs it with halt/timeout supervision.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | waiting for start, CPU held in reset
// S_HEADER    | waiting for header word {ni[15:0], nd[15:0]}
// S_LOAD_INST | writing ni words into instruction memory
// S_LOAD_DATA | writing nd words into data memory
// S_RUN       | CPU released (after one settle cycle), counting run cycles
// S_DONE      | run ended by halt (error=0) or timeout (error=1)
// S_ERROR     | header counts exceed memory depths
module mips_boot_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int INST_DEPTH = 1024,
  parameter int DATA_DEPTH = 1024,
  parameter int RUN_LIMIT  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        cpu_halt,
  mips_boot_sequencer_if.slave bus,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOAD_INST, S_LOAD_DATA, S_RUN, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] INST_MAX = 17'(INST_DEPTH);
  localparam logic [16:0] DATA_MAX = 17'(DATA_DEPTH);
  localparam logic [31:0] LIMIT    = 32'(RUN_LIMIT);

  state_t      state;
  logic [15:0] ni_q;
  logic [15:0] nd_q;
  logic [15:0] idx;

  logic        accept;
  logic [15:0] hdr_ni;
  logic [15:0] hdr_nd;
  logic        hdr_bad;
  logic [31:0] run_next;
  logic        timeout;

  assign accept   = bus.in_valid & bus.in_ready;
  assign hdr_ni   = bus.in_data[31:16];
  assign hdr_nd   = bus.in_data[15:0];
  assign hdr_bad  = ({1'b0, hdr_ni} > INST_MAX) || ({1'b0, hdr_nd} > DATA_MAX);
  assign run_next = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
  assign timeout  = (LIMIT != 32'd0) && (run_next == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      ni_q                  <= '0;
      nd_q                  <= '0;
      idx                   <= '0;
      cpu_rst               <= 1'b1;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      run_cycles            <= '0;
      bus.in_ready          <= 1'b0;
      bus.address           <= '0;
      bus.inst_data         <= '0;
      bus.write_instruction <= 1'b0;
      bus.write_data        <= 1'b0;
    end else begin
      bus.write_instruction <= 1'b0;
      bus.write_data        <= 1'b0;
      if (abort && state != S_IDLE) begin
        state        <= S_IDLE;
        ni_q         <= '0;
        nd_q         <= '0;
        idx          <= '0;
        cpu_rst      <= 1'b1;
        busy         <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
        bus.in_ready <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state        <= S_HEADER;
              cpu_rst      <= 1'b1;
              busy         <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              bus.in_ready <= 1'b1;
            end
          end
          S_HEADER: begin
            if (accept) begin
              ni_q <= hdr_ni;
              nd_q <= hdr_nd;
              idx  <= '0;
              if (hdr_bad) begin
                state        <= S_ERROR;
                busy         <= 1'b0;
                error        <= 1'b1;
                bus.in_ready <= 1'b0;
              end else if (hdr_ni != 16'd0) begin
                state <= S_LOAD_INST;
              end else if (hdr_nd != 16'd0) begin
                state <= S_LOAD_DATA;
              end else begin
                state        <= S_RUN;
                run_cycles   <= '0;
                bus.in_ready <= 1'b0;
              end
            end
          end
          S_LOAD_INST: begin
            if (accept) begin
              bus.address           <= idx[ADDR_W-1:0];
              bus.inst_data         <= bus.in_data;
              bus.write_instruction <= 1'b1;
              if (idx == ni_q - 16'd1) begin
                idx <= '0;
                if (nd_q != 16'd0) begin
                  state <= S_LOAD_DATA;
                end else begin
                  state        <= S_RUN;
                  run_cycles   <= '0;
                  bus.in_ready <= 1'b0;
                end
              end else begin
                idx <= idx + 16'd1;
              end
            end
          end
          S_LOAD_DATA: begin
            if (accept) begin
              bus.address    <= idx[ADDR_W-1:0];
              bus.inst_data  <= bus.in_data;
              bus.write_data <= 1'b1;
              if (idx == nd_q - 16'd1) begin
                idx          <= '0;
                state        <= S_RUN;
                run_cycles   <= '0;
                bus.in_ready <= 1'b0;
              end else begin
                idx <= idx + 16'd1;
              end
            end
          end
          S_RUN: begin
            // cpu_rst is still high on the entry cycle so the last load strobe lands in reset
            if (!cpu_rst) run_cycles <= run_next;
            if (cpu_halt) begin
              state   <= S_DONE;
              cpu_rst <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= 1'b0;
            end else if (!cpu_rst && timeout) begin
              state   <= S_DONE;
              cpu_rst <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= 1'b1;
            end else begin
              cpu_rst <= 1'b0;
            end
          end
          default: begin
            state        <= S_IDLE;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Bench for mips_boot_sequencer: directed loads with a scoreboard of expected load-port writes
// checked by an independent strobe monitor, plus direct checks of status outputs.
module tb_mips_boot_sequencer;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        cpu_halt;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] run_cycles;

  mips_boot_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  mips_boot_sequencer #(
    .ADDR_W(ADDR_W), .INST_DEPTH(1024), .DATA_DEPTH(1024), .RUN_LIMIT(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cpu_halt(cpu_halt),
    .bus(bus), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_inst;
    logic [ADDR_W-1:0] addr;
    logic [31:0]     data;
    int              cyc;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] dvals [5] = '{32'd7, 32'd12, 32'd9, 32'd11, 32'd3};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Strobe monitor: every write must match the next queued expectation, including its cycle.
  always @(negedge clk) begin
    if (bus.write_instruction || bus.write_data) begin
      chk("strobe_exclusive", 32'(bus.write_instruction & bus.write_data), 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got strobe addr 0x%0h data 0x%0h at cycle %0d, expected none",
                 bus.address, bus.inst_data, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_kind", 32'(bus.write_instruction), 32'(e.is_inst));
        chk("strobe_addr", 32'(bus.address), 32'(e.addr));
        chk("strobe_data", bus.inst_data, e.data);
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit push, input bit is_inst, input int addr);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    if (push) sb_q.push_back('{is_inst, addr[ADDR_W-1:0], w, cyc + 1});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic gap();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    tick();
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_address"}, 32'(bus.address), 32'd0);
    chk({tag, "_inst_data"}, bus.inst_data, 32'd0);
    chk({tag, "_wr_inst"}, 32'(bus.write_instruction), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.write_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_run_cycles"}, run_cycles, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cpu_halt = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick(); tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Full load with valid held high, then timeout
    start = 1'b1; tick(); start = 1'b0;
    chk("hdr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("hdr_busy", 32'(busy), 32'd1);
    send(32'h0014_0005, 0, 0, 0);
    chk("inst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) start = 1'b1;
      send(32'hA000_0000 + 32'(k), 1, 1, k);
      start = 1'b0;
    end
    for (int k = 0; k < 5; k++) send(dvals[k], 1, 0, k);
    chk("run_entry_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("run_entry_in_ready", 32'(bus.in_ready), 32'd0);
    chk("run_entry_busy", 32'(busy), 32'd1);
    tick();
    chk("run_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("run_cycles_start", run_cycles, 32'd0);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'd100);
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_run_cycles", run_cycles, 32'd100);
    chk("timeout_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("load1_queue_empty", 32'(sb_q.size()), 32'd0);

    // Same load with valid toggling, then halt at run cycle 37
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_error_clr", 32'(error), 32'd0);
    send(32'h0014_0005, 0, 0, 0);
    gap();
    for (int k = 0; k < 20; k++) begin
      send(32'hB000_0000 + 32'(k), 1, 1, k);
      gap();
    end
    for (int k = 0; k < 5; k++) begin
      send(dvals[k], 1, 0, k);
      if (k != 4) gap();
    end
    chk("gap_run_entry_cpu_rst", 32'(cpu_rst), 32'd1);
    tick();
    chk("gap_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    repeat (36) tick();
    chk("halt_pre_count", run_cycles, 32'd36);
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_error", 32'(error), 32'd0);
    chk("halt_run_cycles", run_cycles, 32'd37);
    chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);

    // Oversized header, then empty image straight to RUN, halt coinciding with timeout
    start = 1'b1; tick(); start = 1'b0;
    send(32'h0401_0000, 0, 0, 0);
    chk("bad_hdr_error", 32'(error), 32'd1);
    chk("bad_hdr_done", 32'(done), 32'd0);
    chk("bad_hdr_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("bad_hdr_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bad_hdr_busy", 32'(busy), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("err_restart_clr", 32'(error), 32'd0);
    send(32'h0000_0000, 0, 0, 0);
    chk("empty_run_busy", 32'(busy), 32'd1);
    chk("empty_run_in_ready", 32'(bus.in_ready), 32'd0);
    chk("empty_run_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("empty_run_cycles_clr", run_cycles, 32'd0);
    tick();
    repeat (99) tick();
    chk("tie_pre_count", run_cycles, 32'd99);
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    chk("tie_done", 32'(done), 32'd1);
    chk("tie_error", 32'(error), 32'd0);
    chk("tie_run_cycles", run_cycles, 32'd100);

    // Abort after the third instruction word, restart from address 0, abort in RUN
    start = 1'b1; tick(); start = 1'b0;
    send(32'h0005_0002, 0, 0, 0);
    for (int k = 0; k < 3; k++) send(32'hC000_0000 + 32'(k), 1, 1, k);
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
    tick();
    abort = 1'b0; bus.in_valid = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    send(32'h0002_0001, 0, 0, 0);
    send(32'hD000_0000, 1, 1, 0);
    send(32'hD000_0001, 1, 1, 1);
    send(32'h0000_00AA, 1, 0, 0);
    tick();
    repeat (5) tick();
    chk("abort_run_count", run_cycles, 32'd5);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_run_busy", 32'(busy), 32'd0);
    chk("abort_run_cpu_rst", 32'(cpu_rst), 32'd1);

    // Synchronous reset in the middle of the data load
    start = 1'b1; tick(); start = 1'b0;
    send(32'h0001_0003, 0, 0, 0);
    send(32'hE000_0000, 1, 1, 0);
    send(32'h0000_0011, 1, 0, 0);
    send(32'h0000_0022, 1, 0, 1);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h0000_0033;
    tick();
    bus.in_valid = 1'b0;
    check_reset_values("midload_rst");
    rst = 1'b0;
    tick(); tick();
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mips_boot_sequencer.md
Name: mips_boot_sequencer

Overview:
Sequences the mini-MIPS CPU from power-up to run. Accepts a program image as a word stream over a valid/ready handshake and writes it into instruction memory, then data memory, via the CPU's existing load port (address, inst_data, write_instruction, write_data). Holds the CPU in reset while loading, releases it, then counts run cycles. Returns the CPU to reset on halt, timeout or abort.

Parameters:
ADDR_W, 10, width of the CPU load address port.
INST_DEPTH, 1024, instruction memory words; the header instruction count must be <= this.
DATA_DEPTH, 1024, data memory words; the header data count must be <= this.
RUN_LIMIT, 100, maximum run cycles before forced stop; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; starts a load from IDLE, DONE or ERROR
abort  input  1  forces IDLE from any non-IDLE state
in_valid  input  1  stream word valid
in_data  input  32  stream word (header, then instruction words, then data words)
in_ready  output  1  sequencer accepts in_data this cycle
cpu_halt  input  1  CPU reports halt
cpu_rst  output  1  reset to the CPU
address  output  ADDR_W  CPU load address
inst_data  output  32  CPU load word
write_instruction  output  1  instruction-memory write strobe
write_data  output  1  data-memory write strobe
busy  output  1  high in HEADER, LOAD_INST, LOAD_DATA and RUN
done  output  1  high in DONE
error  output  1  high in ERROR
run_cycles  output  32  cycles spent in RUN in the current or last run

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: state=IDLE, cpu_rst=1, in_ready=0, address=0, inst_data=0, both write strobes 0, busy/done/error=0, run_cycles=0.
- Acceptance: a word is accepted when in_valid and in_ready are both high. There is no backpressure from memory; in_ready is 1 throughout HEADER, LOAD_INST and LOAD_DATA and 0 elsewhere.
- IDLE: on start, go to HEADER.
- HEADER:
  - Accepting the header latches ni=in_data[31:16] and nd=in_data[15:0].
  - ni>INST_DEPTH or nd>DATA_DEPTH -> ERROR.
  - else ni>0 -> LOAD_INST.
  - else nd>0 -> LOAD_DATA.
  - else -> RUN.
- LOAD_INST:
  - Each accepted word k (k=0..ni-1) registers address=k, inst_data=word and write_instruction=1 on the next cycle (latency 1, one-cycle strobe).
  - After word ni-1, go to LOAD_DATA if nd>0, else RUN.
- LOAD_DATA: same as LOAD_INST, using write_data and index restarting at 0.
- Strobe rules:
  - write_instruction and write_data are never high together.
  - Strobes are 0 in cycles with no accepted word.
  - address/inst_data hold their last value between writes.
  - The final strobe completes in the cycle after the state leaves LOAD_*.
- RUN entry: cpu_rst stays 1 for the first RUN cycle so the final strobe lands while the CPU is held in reset. cpu_rst=0 from the second RUN cycle on.
- RUN counting: run_cycles clears on RUN entry and increments by 1 each RUN cycle with cpu_rst=0 (saturating at 2^32-1).
- RUN exit:
  - cpu_halt -> DONE.
  - RUN_LIMIT!=0 and run_cycles reaches RUN_LIMIT -> DONE with error=1 (timeout).
  - cpu_rst=1 again in the cycle DONE is entered.
  - Simultaneous halt and timeout: halt wins, error=0.
- DONE/ERROR: hold cpu_rst=1 and keep run_cycles. start -> HEADER and clears done/error.
- abort: in any state except IDLE, next state is IDLE with cpu_rst=1 and strobes 0; the load index and counts are discarded. Priority is rst > abort > start > in_valid.
- start: ignored in HEADER, LOAD_* and RUN.
- in_valid outside load states: ignored, no word consumed.
- Reset mid-load: the partially written memory is left as-is; only the sequencer state is reset.

Test Plan:
- Header 0x0014_0005, then 20 instruction words, then data 7,12,9,11,3 with in_valid held high -> 20 write_instruction pulses at addresses 0..19, then 5 write_data pulses at addresses 0..4 with inst_data 7,12,9,11,3. cpu_rst falls exactly 2 cycles after the last data word is accepted.
- Same load with in_valid toggling every other cycle -> identical address/data sequence with gaps; no strobe in any gap cycle.
- Header 0x0401_0000 (ni=1025) -> ERROR next cycle, no strobes, cpu_rst=1. A following start then header 0x0000_0000 -> RUN directly.
- RUN_LIMIT=100 with cpu_halt never asserted -> DONE with error=1 and run_cycles=100. With cpu_halt pulsed at run cycle 37 -> DONE, error=0, run_cycles=37. Halt and timeout in the same cycle -> error=0.
- abort asserted after the 3rd instruction word -> IDLE next cycle, in_ready=0, cpu_rst=1. A restart with a fresh header loads from address 0.
- rst asserted mid LOAD_DATA -> all outputs take their reset values on the next edge.
